// File: rtl/fetch_stage_pkg.sv
// Shared fetch-path widths, default reset PC and the decode-buffer entry type.
package fetch_stage_pkg;

    localparam int unsigned PHY_LEN  = 20;
    localparam int unsigned INST_LEN = 32;

    localparam logic [PHY_LEN-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic [PHY_LEN-1:0]  pc;
        logic [INST_LEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PHY_LEN-1:0] word_align(input logic [PHY_LEN-1:0] addr);
        return addr & ~PHY_LEN'(3);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry decode FIFO. The head is a register and keeps its last value when the FIFO empties.
module fetch_buffer
    import fetch_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

    fetch_entry_t tail;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == DEPTH_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && (count != 2'd0);

    // Push and pop together can only happen with one entry, so the new entry becomes head directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= push_data;
                    end else begin
                        tail <= push_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head <= tail;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    head <= push_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the icache, and queues {pc, instr} for decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PHY_LEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned        BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PHY_LEN-1:0]  ic_addr,
    output logic                ic_enable,
    input  logic [INST_LEN-1:0] ic_instr_data,
    input  logic                ic_miss,
    input  logic                redirect_valid,
    input  logic [PHY_LEN-1:0]  redirect_pc,
    output logic                dec_valid,
    input  logic                dec_ready,
    output logic [INST_LEN-1:0] dec_instr,
    output logic [PHY_LEN-1:0]  dec_pc,
    output logic [31:0]         miss_cycles
);

    typedef enum logic {
        FETCH,
        MISS
    } fetch_state_t;

    fetch_state_t       state, state_next;
    logic               stale, stale_next;
    logic               push;
    logic [PHY_LEN-1:0] pc;
    logic               buf_full;
    logic [1:0]         buf_count;
    fetch_entry_t       push_entry;
    fetch_entry_t       head;

    assign ic_addr    = pc;
    assign ic_enable  = rst && !buf_full && !redirect_valid;
    assign push_entry = '{pc: pc, instr: ic_instr_data};

    assign dec_valid = (buf_count != 2'd0);
    assign dec_pc    = head.pc;
    assign dec_instr = head.instr;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (dec_valid && dec_ready),
        .flush     (redirect_valid),
        .full      (buf_full),
        .count     (buf_count),
        .head      (head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
            stale <= 1'b0;
        end else begin
            state <= state_next;
            stale <= stale_next;
        end
    end

    // A redirect during a miss marks the in-flight refill stale; its data is dropped when it lands.
    always_comb begin
        state_next = state;
        stale_next = stale;
        push       = 1'b0;
        case (state)
            FETCH: begin
                if (ic_enable) begin
                    if (ic_miss) begin
                        state_next = MISS;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            MISS: begin
                if (redirect_valid) begin
                    stale_next = 1'b1;
                end
                if (!ic_miss) begin
                    state_next = FETCH;
                    stale_next = 1'b0;
                    push       = ic_enable && !stale;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= word_align(redirect_pc);
        end else if (push) begin
            pc <= pc + PHY_LEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_cycles <= '0;
        end else if (state == MISS && miss_cycles != '1) begin
            miss_cycles <= miss_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: an icache behaviour model and a queue reference of the
// decode stream are stepped by the driver; a separate monitor checks the DUT every cycle.
module tb_fetch_stage;

    localparam logic [19:0] RST_PC = 20'h00000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] ic_addr;
    logic        ic_enable;
    logic [31:0] ic_instr_data = '0;
    logic        ic_miss = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [19:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [19:0] dec_pc;
    logic [31:0] miss_cycles;

    fetch_stage #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ic_addr        (ic_addr),
        .ic_enable      (ic_enable),
        .ic_instr_data  (ic_instr_data),
        .ic_miss        (ic_miss),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .miss_cycles    (miss_cycles)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    logic [51:0] exp_q[$];

    // Reference model state.
    logic        rst_req    = 1'b0;
    logic [19:0] m_pc       = RST_PC;
    int          occ        = 0;
    int          busy       = 0;
    bit          refill     = 1'b0;
    logic [19:0] miss_addr  = '0;
    int          epoch      = 0;
    int          miss_epoch = 0;
    logic [31:0] exp_miss   = '0;

    // Expectations for the cycle currently being presented.
    logic [19:0] cur_pc   = RST_PC;
    bit          cur_en   = 1'b0;
    int          cur_occ  = 0;
    bit          cur_idle = 1'b1;
    logic [31:0] cur_miss = '0;

    function automatic logic [31:0] line_word(input logic [19:0] a);
        return {a, 12'h5A3} ^ {12'hC3F, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus. miss_req: >0 start a miss of that length if a fetch is issued,
    // 0 never start a miss, <0 random misses and random ic_miss while not fetching.
    task automatic step(input bit redir, input logic [19:0] rpc, input bit rdy, input int miss_req);
        bit en;
        bit accept;
        bit pop;
        int len;
        @(negedge clk);
        rst            = rst_req;
        redirect_valid = redir;
        redirect_pc    = rpc;
        dec_ready      = rdy;
        if (!rst_req) begin
            m_pc = RST_PC; occ = 0; busy = 0; refill = 1'b0; exp_miss = '0;
            exp_q.delete();
            ic_miss = 1'b0; ic_instr_data = $urandom;
            cur_pc = RST_PC; cur_en = 1'b0; cur_occ = 0; cur_idle = 1'b1; cur_miss = '0;
            return;
        end
        en       = (occ < 2) && !redir;
        cur_pc   = m_pc;
        cur_en   = en;
        cur_occ  = occ;
        cur_idle = (busy == 0) && !refill;
        cur_miss = exp_miss;
        accept   = 1'b0;
        if (refill) begin
            ic_miss       = 1'b0;
            ic_instr_data = line_word(miss_addr);
            accept        = en && (epoch == miss_epoch);
            refill        = 1'b0;
        end else if (busy > 0) begin
            ic_miss       = 1'b1;
            ic_instr_data = $urandom;
            busy--;
            refill        = (busy == 0);
        end else if (en && (miss_req > 0 || (miss_req < 0 && $urandom_range(0, 7) == 0))) begin
            len           = (miss_req > 0) ? miss_req : int'($urandom_range(1, 5));
            ic_miss       = 1'b1;
            ic_instr_data = $urandom;
            miss_addr     = m_pc;
            miss_epoch    = epoch;
            busy          = len - 1;
            refill        = (busy == 0);
            exp_miss      = exp_miss + 32'(len);
        end else begin
            ic_miss       = (!en && miss_req < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            ic_instr_data = line_word(m_pc);
            accept        = en;
        end
        if (accept) exp_q.push_back({m_pc, ic_instr_data});
        pop = !redir && rdy && (occ > 0);
        if (redir) begin
            occ = 0;
            exp_q.delete();
            m_pc = rpc & 20'hFFFFC;
            epoch++;
        end else begin
            occ = occ + int'(accept) - int'(pop);
            if (accept) m_pc = m_pc + 20'd4;
        end
    endtask

    initial begin : monitor
        logic [51:0] e;
        forever begin
            @(negedge clk);
            #4;
            chk("ic_addr", 64'(ic_addr), 64'(cur_pc));
            chk("ic_enable", 64'(ic_enable), 64'(cur_en));
            chk("dec_valid", 64'(dec_valid), 64'(cur_occ > 0));
            if (!rst) begin
                chk("reset_dec_pc", 64'(dec_pc), 64'd0);
                chk("reset_dec_instr", 64'(dec_instr), 64'd0);
                chk("reset_miss_cycles", 64'(miss_cycles), 64'd0);
            end else begin
                if (cur_idle) chk("miss_cycles", 64'(miss_cycles), 64'(cur_miss));
                if (dec_valid && dec_ready && !redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        failed++;
                        $display("FAIL deq_unexpected: got pc 0x%0h, required no entry", dec_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dec_pc", 64'(dec_pc), 64'(e[51:32]));
                        chk("dec_instr", 64'(dec_instr), 64'(e[31:0]));
                    end
                end
            end
        end
    end

    initial begin : driver
        repeat (3) step(1'b0, '0, 1'b1, 0);
        rst_req = 1'b1;

        // Streaming hits from reset.
        repeat (10) step(1'b0, '0, 1'b1, 0);

        // Five-cycle miss at 0x10.
        step(1'b1, 20'h00010, 1'b1, 0);
        step(1'b0, '0, 1'b1, 5);
        repeat (8) step(1'b0, '0, 1'b1, 0);

        // Decode back-pressure fills the buffer, then drains in order.
        step(1'b1, 20'h00000, 1'b0, 0);
        repeat (4) step(1'b0, '0, 1'b0, 0);
        repeat (4) step(1'b0, '0, 1'b1, 0);

        // Redirect with a full buffer and a simultaneous dequeue.
        repeat (3) step(1'b0, '0, 1'b0, 0);
        step(1'b1, 20'h00403, 1'b1, 0);
        repeat (4) step(1'b0, '0, 1'b1, 0);

        // Redirect while a miss on 0x40 is outstanding.
        step(1'b1, 20'h00040, 1'b1, 0);
        step(1'b0, '0, 1'b1, 4);
        step(1'b1, 20'h00200, 1'b1, 0);
        repeat (6) step(1'b0, '0, 1'b1, 0);

        // PC wrap, then asynchronous reset in the middle of a miss.
        step(1'b1, 20'hFFFFC, 1'b1, 0);
        repeat (3) step(1'b0, '0, 1'b1, 0);
        step(1'b0, '0, 1'b1, 6);
        repeat (2) step(1'b0, '0, 1'b1, 0);
        @(posedge clk);
        #2;
        rst     = 1'b0;
        rst_req = 1'b0;
        #1;
        chk("async_rst_dec_valid", 64'(dec_valid), 64'd0);
        chk("async_rst_ic_enable", 64'(ic_enable), 64'd0);
        chk("async_rst_ic_addr", 64'(ic_addr), 64'(RST_PC));
        chk("async_rst_miss_cycles", 64'(miss_cycles), 64'd0);
        chk("async_rst_dec_pc", 64'(dec_pc), 64'd0);
        chk("async_rst_dec_instr", 64'(dec_instr), 64'd0);
        repeat (2) step(1'b0, '0, 1'b1, 0);
        rst_req = 1'b1;
        repeat (4) step(1'b0, '0, 1'b1, 0);

        // Randomised traffic: misses, redirects and decode stalls.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 15) == 0, 20'($urandom), $urandom_range(0, 3) != 0, -1);
        end
        repeat (2) step(1'b0, '0, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
